// File: rtl/muldiv_sequencer_if.sv
// Bus between the EX stage and the multiply/divide sequencer.
interface muldiv_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             Valid;
  logic [2:0]       ALUOp;
  logic [5:0]       ALUFunction;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Flush;
  logic             Stall;
  logic             Busy;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  logic [WIDTH-1:0] MfData;

  // EX-stage side: presents the instruction, consumes stall and results
  modport master (
    output Valid, ALUOp, ALUFunction, A, B, Flush,
    input  Stall, Busy, HI, LO, MfData
  );

  // Sequencer side
  modport slave (
    input  Valid, ALUOp, ALUFunction, A, B, Flush,
    output Stall, Busy, HI, LO, MfData
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer with HI/LO registers for the EX stage.
// One shift-add (multiply) or restoring-subtract (divide) step per cycle on
// operand magnitudes; the sign is applied when the result is written to HI/LO.
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input logic                clk,
  input logic                reset,
  muldiv_sequencer_if.slave  bus
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_RTYPE = 3'b111;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  // acc: running high product / partial remainder
  // qr:  multiplier being consumed / dividend shifting out, quotient shifting in
  // m:   multiplicand / divisor magnitude
  logic [WIDTH-1:0] acc_q, acc_d, qr_q, qr_d, m_q, m_d;
  logic             div_q, div_d;
  logic             negres_q, negres_d;
  logic             negrem_q, negrem_d;

  logic             rtype, op_start, is_div, signed_op, issue;
  logic             sa, sb;
  logic [WIDTH-1:0] abs_a, abs_b;

  logic [WIDTH:0]     add_sum, rem_sh, diff;
  logic [WIDTH-1:0]   acc_nx, qr_nx;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Instruction decode and operand sign handling
  always_comb begin
    rtype     = bus.Valid && (bus.ALUOp == OP_RTYPE);
    op_start  = rtype && ((bus.ALUFunction == F_MULT) || (bus.ALUFunction == F_MULTU) ||
                          (bus.ALUFunction == F_DIV)  || (bus.ALUFunction == F_DIVU));
    is_div    = bus.ALUFunction[1];
    signed_op = ~bus.ALUFunction[0];
    issue     = (state_q == S_IDLE) && op_start && !bus.Flush;
    sa        = signed_op & bus.A[WIDTH-1];
    sb        = signed_op & bus.B[WIDTH-1];
    abs_a     = sa ? (~bus.A + 1'b1) : bus.A;
    abs_b     = sb ? (~bus.B + 1'b1) : bus.B;
  end

  // One iteration of the shift-add multiplier or restoring divider
  always_comb begin
    add_sum = {1'b0, acc_q} + (qr_q[0] ? {1'b0, m_q} : '0);
    rem_sh  = {acc_q, qr_q[WIDTH-1]};
    diff    = rem_sh - {1'b0, m_q};
    if (div_q) begin
      if (!diff[WIDTH]) begin
        acc_nx = diff[WIDTH-1:0];
        qr_nx  = {qr_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_nx = rem_sh[WIDTH-1:0];
        qr_nx  = {qr_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      {acc_nx, qr_nx} = {add_sum, qr_q[WIDTH-1:1]};
    end
    prod     = {acc_nx, qr_nx};
    prod_fix = negres_q ? (~prod + 1'b1) : prod;
    quo_fix  = negres_q ? (~qr_nx + 1'b1) : qr_nx;
    rem_fix  = negrem_q ? (~acc_nx + 1'b1) : acc_nx;
  end

  // Next-state, datapath and HI/LO update
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    acc_d    = acc_q;
    qr_d     = qr_q;
    m_d      = m_q;
    div_d    = div_q;
    negres_d = negres_q;
    negrem_d = negrem_q;
    case (state_q)
      S_IDLE: begin
        if (issue) begin
          div_d    = is_div;
          negres_d = sa ^ sb;
          negrem_d = sa;
          acc_d    = '0;
          if (is_div && (bus.B == '0)) begin
            hi_d    = bus.A;
            lo_d    = '1;
            state_d = S_DONE;
          end else begin
            qr_d    = is_div ? abs_a : abs_b;
            m_d     = is_div ? abs_b : abs_a;
            cnt_d   = CW'(WIDTH - 1);
            state_d = S_BUSY;
          end
        end else if (rtype && !bus.Flush) begin
          if (bus.ALUFunction == F_MTHI) hi_d = bus.A;
          if (bus.ALUFunction == F_MTLO) lo_d = bus.A;
        end
      end
      S_BUSY: begin
        if (bus.Flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = acc_nx;
          qr_d  = qr_nx;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_d = S_DONE;
            if (div_q) begin
              hi_d = rem_fix;
              lo_d = quo_fix;
            end else begin
              {hi_d, lo_d} = prod_fix;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and register update with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      acc_q    <= '0;
      qr_q     <= '0;
      m_q      <= '0;
      div_q    <= 1'b0;
      negres_q <= 1'b0;
      negrem_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      acc_q    <= acc_d;
      qr_q     <= qr_d;
      m_q      <= m_d;
      div_q    <= div_d;
      negres_q <= negres_d;
      negrem_q <= negrem_d;
    end
  end

  // Outputs: stall covers the issue cycle and every uncancelled BUSY cycle
  always_comb begin
    bus.Stall  = reset && (issue || ((state_q == S_BUSY) && !bus.Flush));
    bus.Busy   = (state_q == S_BUSY);
    bus.HI     = hi_q;
    bus.LO     = lo_q;
    bus.MfData = '0;
    if (rtype && (bus.ALUFunction == F_MFHI)) bus.MfData = hi_q;
    if (rtype && (bus.ALUFunction == F_MFLO)) bus.MfData = lo_q;
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer against an arithmetic reference model.
module tb_muldiv_sequencer;

  localparam int W = 32;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muldiv_sequencer_if #(.WIDTH(W)) bus ();
  muldiv_sequencer #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;

  // Reference result {HI, LO} from plain arithmetic
  function automatic logic [63:0] ref_res(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = '0;
    case (f)
      F_MULT:  res = 64'(sa * sb);
      F_MULTU: res = {32'b0, a} * {32'b0, b};
      F_DIV: begin
        if (b == 0) res = {a, 32'hFFFFFFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      F_DIVU: begin
        if (b == 0) res = {a, 32'hFFFFFFFF};
        else res = {a % b, a / b};
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  task automatic drive(input logic v, input logic [2:0] op, input logic [5:0] f,
                       input logic [31:0] a, input logic [31:0] b, input logic fl);
    bus.Valid = v;
    bus.ALUOp = op;
    bus.ALUFunction = f;
    bus.A = a;
    bus.B = b;
    bus.Flush = fl;
  endtask

  // Presents an op and holds it while stalled; returns stall/busy cycle counts
  task automatic do_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       output int sc, output int bc, output logic hung);
    @(negedge clk);
    drive(1'b1, 3'b111, f, a, b, 1'b0);
    sc = 0;
    bc = 0;
    hung = 1'b1;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (bus.Stall) sc++;
      if (bus.Busy) bc++;
      if (!bus.Stall) begin
        hung = 1'b0;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.Valid = 1'b0;
  endtask

  task automatic check_op(input string name, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    int sc, bc, esc, ebc;
    logic hung;
    logic [63:0] exp;
    exp = ref_res(f, a, b);
    esc = (f[1] && b == 0) ? 1 : W + 1;
    ebc = (f[1] && b == 0) ? 0 : W;
    do_op(f, a, b, sc, bc, hung);
    n_cmp++;
    if (hung !== 1'b0) begin
      n_err++;
      $display("FAIL %s timeout: stall never dropped (A=%h B=%h)", name, a, b);
    end
    n_cmp++;
    if (sc !== esc) begin
      n_err++;
      $display("FAIL %s stall_cycles got %0d exp %0d", name, sc, esc);
    end
    n_cmp++;
    if (bc !== ebc) begin
      n_err++;
      $display("FAIL %s busy_cycles got %0d exp %0d", name, bc, ebc);
    end
    n_cmp++;
    if (bus.HI !== exp[63:32]) begin
      n_err++;
      $display("FAIL %s HI got %h exp %h (A=%h B=%h)", name, bus.HI, exp[63:32], a, b);
    end
    n_cmp++;
    if (bus.LO !== exp[31:0]) begin
      n_err++;
      $display("FAIL %s LO got %h exp %h (A=%h B=%h)", name, bus.LO, exp[31:0], a, b);
    end
    n_cmp++;
    if (bus.Busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s reissue_after_done Busy got %b exp 0", name, bus.Busy);
    end
  endtask

  task automatic move_to(input logic [5:0] f, input logic [31:0] val);
    @(negedge clk);
    drive(1'b1, 3'b111, f, val, $urandom, 1'b0);
    #1;
    n_cmp++;
    if (bus.Stall !== 1'b0) begin
      n_err++;
      $display("FAIL mt_stall got %b exp 0", bus.Stall);
    end
    @(posedge clk);
    #1;
    bus.Valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1'b1, 3'b111, F_MULT, 32'd5, 32'd7, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (bus.Stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b exp 0", bus.Stall); end
    n_cmp++;
    if (bus.Busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", bus.Busy); end
    n_cmp++;
    if (bus.HI !== 32'h0 || bus.LO !== 32'h0) begin
      n_err++;
      $display("FAIL reset_hilo got %h/%h exp 0/0", bus.HI, bus.LO);
    end
    bus.Valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_directed();
    check_op("multu_max", F_MULTU, 32'hFFFFFFFF, 32'd2);
    check_op("mult_neg",  F_MULT,  32'hFFFFFFFD, 32'd5);
    check_op("div_neg",   F_DIV,   32'hFFFFFFF9, 32'd2);
    check_op("divu",      F_DIVU,  32'd100,      32'd7);
  endtask

  task automatic test_div_corner();
    check_op("divu_zero", F_DIVU, 32'h00001234, 32'h0);
    check_op("div_zero",  F_DIV,  32'h80000005, 32'h0);
    check_op("div_ovf",   F_DIV,  32'h80000000, 32'hFFFFFFFF);
  endtask

  task automatic test_decode_ignore();
    // Non-R-type ALUOp and an unrelated funct must not start anything
    @(negedge clk);
    drive(1'b1, 3'b000, F_MULT, 32'd3, 32'd3, 1'b0);
    #1;
    n_cmp++;
    if (bus.Stall !== 1'b0) begin n_err++; $display("FAIL ignore_aluop stall got %b exp 0", bus.Stall); end
    @(negedge clk);
    drive(1'b1, 3'b111, 6'b100000, 32'd3, 32'd3, 1'b0);
    #1;
    n_cmp++;
    if (bus.Stall !== 1'b0) begin n_err++; $display("FAIL ignore_funct stall got %b exp 0", bus.Stall); end
    @(posedge clk);
    #1;
    bus.Valid = 1'b0;
    n_cmp++;
    if (bus.Busy !== 1'b0) begin n_err++; $display("FAIL ignore_busy got %b exp 0", bus.Busy); end
  endtask

  task automatic test_mt_mf();
    logic [31:0] v;
    move_to(F_MTHI, 32'hCAFE0000);
    move_to(F_MTLO, 32'h0000BEEF);
    @(negedge clk);
    drive(1'b1, 3'b111, F_MFHI, $urandom, $urandom, 1'b0);
    #1;
    n_cmp++;
    if (bus.MfData !== 32'hCAFE0000 || bus.Stall !== 1'b0) begin
      n_err++;
      $display("FAIL mfhi MfData/Stall got %h/%b exp cafe0000/0", bus.MfData, bus.Stall);
    end
    @(negedge clk);
    drive(1'b1, 3'b111, F_MFLO, $urandom, $urandom, 1'b0);
    #1;
    n_cmp++;
    if (bus.MfData !== 32'h0000BEEF || bus.Stall !== 1'b0) begin
      n_err++;
      $display("FAIL mflo MfData/Stall got %h/%b exp 0000beef/0", bus.MfData, bus.Stall);
    end
    @(negedge clk);
    drive(1'b1, 3'b111, F_MTHI, 32'h0, 32'h0, 1'b0);
    bus.Valid = 1'b0;
    #1;
    n_cmp++;
    if (bus.MfData !== 32'h0) begin n_err++; $display("FAIL mf_idle MfData got %h exp 0", bus.MfData); end
    v = $urandom;
    move_to(F_MTLO, v);
    n_cmp++;
    if (bus.LO !== v || bus.HI !== 32'hCAFE0000) begin
      n_err++;
      $display("FAIL mtlo_rand HI/LO got %h/%h exp cafe0000/%h", bus.HI, bus.LO, v);
    end
  endtask

  task automatic test_flush();
    move_to(F_MTHI, 32'h11);
    move_to(F_MTLO, 32'h22);
    @(negedge clk);
    drive(1'b1, 3'b111, F_MULTU, $urandom, $urandom | 32'h1, 1'b0);
    repeat (10) @(negedge clk);
    n_cmp++;
    #1;
    if (bus.Busy !== 1'b1) begin n_err++; $display("FAIL flush_pre_busy got %b exp 1", bus.Busy); end
    bus.Flush = 1'b1;
    #1;
    n_cmp++;
    if (bus.Stall !== 1'b0) begin n_err++; $display("FAIL flush_stall got %b exp 0", bus.Stall); end
    @(posedge clk);
    #1;
    bus.Flush = 1'b0;
    bus.Valid = 1'b0;
    n_cmp++;
    if (bus.Busy !== 1'b0) begin n_err++; $display("FAIL flush_idle Busy got %b exp 0", bus.Busy); end
    n_cmp++;
    if (bus.HI !== 32'h11 || bus.LO !== 32'h22) begin
      n_err++;
      $display("FAIL flush_hilo got %h/%h exp 11/22", bus.HI, bus.LO);
    end
    // Flush in the issue cycle: nothing starts
    @(negedge clk);
    drive(1'b1, 3'b111, F_DIVU, 32'd50, 32'd3, 1'b1);
    #1;
    n_cmp++;
    if (bus.Stall !== 1'b0) begin n_err++; $display("FAIL flush_issue stall got %b exp 0", bus.Stall); end
    @(posedge clk);
    #1;
    bus.Valid = 1'b0;
    bus.Flush = 1'b0;
    n_cmp++;
    if (bus.Busy !== 1'b0) begin n_err++; $display("FAIL flush_issue busy got %b exp 0", bus.Busy); end
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    drive(1'b1, 3'b111, F_DIVU, 32'd1000, 32'd7, 1'b0);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++;
    if (bus.Busy !== 1'b0 || bus.Stall !== 1'b0) begin
      n_err++;
      $display("FAIL midreset Busy/Stall got %b/%b exp 0/0", bus.Busy, bus.Stall);
    end
    n_cmp++;
    if (bus.HI !== 32'h0 || bus.LO !== 32'h0) begin
      n_err++;
      $display("FAIL midreset HI/LO got %h/%h exp 0/0", bus.HI, bus.LO);
    end
    bus.Valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check_op("post_reset_multu", F_MULTU, 32'd3, 32'd4);
  endtask

  function automatic logic [31:0] pick(input bit allow_zero);
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0: v = 32'h80000000;
      1: v = 32'hFFFFFFFF;
      2: v = 32'($urandom_range(1, 20));
      3: v = allow_zero ? 32'h0 : 32'h1;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  task automatic test_back_to_back();
    logic [5:0] f;
    for (int i = 0; i < 24; i++) begin
      f = 6'b011000 | 6'($urandom_range(0, 3));
      check_op($sformatf("rand%0d", i), f, pick(1'b0), pick(1'b1));
    end
  endtask

  initial begin
    drive(1'b0, 3'b000, 6'h0, 32'h0, 32'h0, 1'b0);
    test_reset();
    test_directed();
    test_div_corner();
    test_decode_ignore();
    test_mt_mf();
    test_flush();
    test_reset_midop();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
